// File: rtl/tc_spi_if.sv
// tc_spi_if: SPI master handshake seen by the thermocouple scheduler.
interface tc_spi_if #(
    parameter int NCH = 4
) ();
    localparam int CW = $clog2(NCH);
    logic          spi_ena;
    logic [CW-1:0] spi_cs_sel;
    logic          spi_not_busy;
    logic [31:0]   spi_rx_data;
    modport master (output spi_ena, spi_cs_sel, input spi_not_busy, spi_rx_data);
    modport slave  (input spi_ena, spi_cs_sel, output spi_not_busy, spi_rx_data);
endinterface

// File: rtl/tc_spi_scheduler.sv
// tc_spi_scheduler: round-robin MAX31855 poller sharing one SPI master.
// Define TC_SCHED_TIMEOUT_EN to add the REQ/BUSY watchdog and timeout_err.
module tc_spi_scheduler #(
    parameter int NCH = 4,
    parameter int STARTUP = 900,
    parameter int PERIOD = 300,
    parameter int TIMEOUT = 64,
    localparam int CW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    tc_spi_if.master        spi,
    input  logic [NCH-1:0]  ch_enable,
    input  logic [CW-1:0]   rd_ch,
    output logic [13:0]     rd_tc_temp,
    output logic [11:0]     rd_junction_temp,
    output logic [3:0]      rd_fault,
    output logic [NCH-1:0]  data_valid,
    output logic            sample_strobe,
    output logic [CW-1:0]   sample_ch,
    output logic            timeout_err
);
    localparam int MX1 = STARTUP > PERIOD ? STARTUP : PERIOD;
    localparam int MX = MX1 > TIMEOUT ? MX1 : TIMEOUT;
    localparam int CNTW = $clog2(MX + 1);
    typedef enum logic [2:0] {S_STARTUP, S_IDLE, S_SELECT, S_REQ, S_BUSY, S_CAPTURE, S_WAIT} state_t;
    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [NCH-1:0]  mask, rest;
    logic [CW-1:0]   nxt;
    logic            abort;
    logic [13:0]     tc [2**CW];
    logic [11:0]     jt [2**CW];
    logic [3:0]      ft [2**CW];
    function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] m);
        logic [CW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) if (m[i]) r = CW'(i);
        return r;
    endfunction
    // Channels are served in ascending order, so the lowest remaining bit is the next higher one.
    assign rest = mask & ~(NCH'(1) << spi.spi_cs_sel);
    assign nxt = lowest(rest);
    // Unused entries above NCH-1 are never written, so out-of-range reads return 0.
    assign rd_tc_temp = tc[rd_ch];
    assign rd_junction_temp = jt[rd_ch];
    assign rd_fault = ft[rd_ch];
`ifdef TC_SCHED_TIMEOUT_EN
    assign abort = (state == S_REQ || state == S_BUSY) && cnt == CNTW'(TIMEOUT - 1);
`else
    assign abort = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_STARTUP;
            cnt <= '0;
            mask <= '0;
            spi.spi_ena <= 1'b0;
            spi.spi_cs_sel <= '0;
            data_valid <= '0;
            sample_strobe <= 1'b0;
            sample_ch <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 2**CW; i++) begin
                tc[i] <= '0;
                jt[i] <= '0;
                ft[i] <= '0;
            end
        end else begin
            sample_strobe <= 1'b0;
            if (abort) begin
                spi.spi_ena <= 1'b0;
                timeout_err <= 1'b1;
                mask <= rest;
                spi.spi_cs_sel <= nxt;
                cnt <= '0;
                state <= |rest ? S_SELECT : S_WAIT;
            end else begin
                case (state)
                    S_STARTUP: begin
                        cnt <= cnt == CNTW'(STARTUP - 1) ? '0 : cnt + 1'b1;
                        state <= cnt == CNTW'(STARTUP - 1) ? S_IDLE : S_STARTUP;
                    end
                    S_IDLE: begin
                        mask <= ch_enable;
                        spi.spi_cs_sel <= lowest(ch_enable);
                        cnt <= '0;
                        state <= |ch_enable ? S_SELECT : S_WAIT;
                    end
                    S_SELECT: begin
                        spi.spi_ena <= 1'b1;
                        cnt <= '0;
                        state <= S_REQ;
                    end
                    S_REQ: begin
                        cnt <= cnt + 1'b1;
                        spi.spi_ena <= spi.spi_not_busy;
                        state <= spi.spi_not_busy ? S_REQ : S_BUSY;
                    end
                    S_BUSY: begin
                        cnt <= cnt + 1'b1;
                        state <= spi.spi_not_busy ? S_CAPTURE : S_BUSY;
                    end
                    S_CAPTURE: begin
                        tc[spi.spi_cs_sel] <= spi.spi_rx_data[31:18];
                        jt[spi.spi_cs_sel] <= spi.spi_rx_data[15:4];
                        ft[spi.spi_cs_sel] <= {spi.spi_rx_data[16], spi.spi_rx_data[2:0]};
                        data_valid[spi.spi_cs_sel] <= 1'b1;
                        sample_strobe <= 1'b1;
                        sample_ch <= spi.spi_cs_sel;
                        mask <= rest;
                        spi.spi_cs_sel <= nxt;
                        cnt <= '0;
                        state <= |rest ? S_SELECT : S_WAIT;
                    end
                    default: begin
                        cnt <= cnt == CNTW'(PERIOD - 1) ? '0 : cnt + 1'b1;
                        state <= cnt == CNTW'(PERIOD - 1) ? S_IDLE : S_WAIT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tc_spi_scheduler.sv
// tb_tc_spi_scheduler: scoreboard bench for tc_spi_scheduler with a 10-cycle SPI slave model.
module tb_tc_spi_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_enable = 4'hF;
    logic [1:0]  rd_ch = 2'd0;
    logic [13:0] rd_tc_temp;
    logic [11:0] rd_junction_temp;
    logic [3:0]  rd_fault;
    logic [3:0]  data_valid;
    logic        sample_strobe;
    logic [1:0]  sample_ch;
    logic        timeout_err;
    int n_chk = 0, n_fail = 0, cyc = 0, nstrobe = 0, peek = -1;
    logic stuck = 1'b0;
    logic [3:0] cs_allow = 4'hF;
    int exp_q [$];
    logic [31:0] frm  [4] = '{32'h0190_1910, 32'hFFFC_0000, 32'hABCD_5A27, 32'h0001_FFF5};
    logic [13:0] e_tc [4] = '{14'h0064, 14'h3FFF, 14'h2AF3, 14'h0000};
    logic [11:0] e_jt [4] = '{12'h191, 12'h000, 12'h5A2, 12'hFFF};
    logic [3:0]  e_ft [4] = '{4'h0, 4'h0, 4'hF, 4'hD};

    tc_spi_if #(.NCH(4)) spi ();
    tc_spi_scheduler #(.NCH(4), .STARTUP(900), .PERIOD(300), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .spi(spi), .ch_enable(ch_enable), .rd_ch(rd_ch),
        .rd_tc_temp(rd_tc_temp), .rd_junction_temp(rd_junction_temp), .rd_fault(rd_fault),
        .data_valid(data_valid), .sample_strobe(sample_strobe), .sample_ch(sample_ch),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_ena(output int c);
        c = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (spi.spi_ena) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ena: no spi_ena within 3000 cycles");
        end
    endtask

    task automatic wait_strobe_ch(input int ch, output int c);
        c = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sample_strobe && sample_ch == 2'(ch)) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_strobe: no strobe for channel %0d within 3000 cycles", ch);
        end
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!spi.spi_not_busy) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_busy: SPI model never went busy");
    endtask

    // SPI slave: goes busy for 10 cycles per request, then presents the frame of the selected channel.
    initial begin
        logic [1:0] cs;
        spi.spi_not_busy = 1'b1;
        spi.spi_rx_data = '0;
        forever begin
            @(negedge clk);
            if (spi.spi_ena && spi.spi_not_busy && !stuck) begin
                cs = spi.spi_cs_sel;
                spi.spi_not_busy = 1'b0;
                repeat (10) @(negedge clk);
                spi.spi_rx_data = frm[cs];
                spi.spi_not_busy = 1'b1;
            end
        end
    end

    // Monitor: pops the expected channel on every strobe and checks the captured registers.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (spi.spi_ena) chk("cs_allowed", 32'(cs_allow[spi.spi_cs_sel]), 1);
            if (sample_strobe) begin
                nstrobe++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: channel %0d, nothing expected", sample_ch);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample_ch", 32'(sample_ch), e);
                    rd_ch = 2'(e);
                    #1;
                    chk("rd_tc_temp", 32'(rd_tc_temp), 32'(e_tc[e]));
                    chk("rd_junction_temp", 32'(rd_junction_temp), 32'(e_jt[e]));
                    chk("rd_fault", 32'(rd_fault), 32'(e_ft[e]));
                end
            end else if (peek >= 0) begin
                rd_ch = 2'(peek);
                #1;
                chk("peek_tc_temp", 32'(rd_tc_temp), 32'(e_tc[peek]));
                chk("peek_junction_temp", 32'(rd_junction_temp), 32'(e_jt[peek]));
                chk("peek_fault", 32'(rd_fault), 32'(e_ft[peek]));
                peek = -1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int c, t, n;
        repeat (3) @(negedge clk);
        chk("reset_spi_ena", 32'(spi.spi_ena), 0);
        chk("reset_data_valid", 32'(data_valid), 0);
        chk("reset_strobe", 32'(sample_strobe), 0);
        chk("reset_tc_temp", 32'(rd_tc_temp), 0);
        chk("reset_cs_sel", 32'(spi.spi_cs_sel), 0);
        chk("reset_timeout_err", 32'(timeout_err), 0);
        exp_q = '{0, 1, 2, 3};
        rst = 1'b0;
        wait_ena(c);
        chk("first_ena_cycle", c, 902);
        wait_strobe_ch(3, t);
        chk("data_valid_round1", 32'(data_valid), 32'hF);
        ch_enable = 4'b1010;
        cs_allow = 4'b1010;
        exp_q.push_back(1);
        exp_q.push_back(3);
        wait_strobe_ch(3, t);
        ch_enable = 4'b0001;
        cs_allow = 4'b0001;
        exp_q.push_back(0);
        wait_ena(c);
        chk("strobe_to_ena_gap", c - t, 302);
        wait_busy();
        ch_enable = 4'b0100;
        exp_q.push_back(2);
        wait_strobe_ch(0, t);
        cs_allow = 4'b0100;
        wait_strobe_ch(2, t);
        chk("data_valid_sticky", 32'(data_valid), 32'hF);
        peek = 0;
        for (int i = 0; i < 20 && peek >= 0; i++) @(negedge clk);
        chk("peek_serviced", peek, -1);
        wait_ena(c);
        wait_busy();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_spi_ena", 32'(spi.spi_ena), 0);
        chk("midrst_data_valid", 32'(data_valid), 0);
        chk("midrst_strobe", 32'(sample_strobe), 0);
        chk("midrst_tc_temp", 32'(rd_tc_temp), 0);
        chk("midrst_fault", 32'(rd_fault), 0);
        @(negedge clk);
        exp_q.push_back(2);
        rst = 1'b0;
        wait_ena(c);
        chk("restart_ena_cycle", c, 902);
        wait_strobe_ch(2, t);
        chk("data_valid_after_restart", 32'(data_valid), 32'h4);
`ifdef TC_SCHED_TIMEOUT_EN
        stuck = 1'b1;
        ch_enable = 4'b0011;
        cs_allow = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            wait_ena(c);
            n = 1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (!spi.spi_ena) break;
                n++;
            end
            chk("timeout_ena_cycles", n, 64);
            chk("timeout_err_set", 32'(timeout_err), 1);
            chk("timeout_cs_sel", 32'(dut.sample_ch), 2);
        end
        chk("timeout_data_valid", 32'(data_valid), 32'h4);
`else
        chk("timeout_err_tied", 32'(timeout_err), 0);
`endif
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
